// File: rtl/alu16_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu16_op_sequencer
// Brief    : Command-driven master for the 16-bit ALU bus with programmable
//            settle time, carry chaining and a FWFT response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module alu16_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int RSP_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_mode,
    input  logic        cmd_cin,
    input  logic        cmd_chain,
    output logic [15:0] operand_a,
    output logic [15:0] operand_b,
    output logic [3:0]  opcode,
    output logic        mode,
    output logic        carry_in,
    input  logic [15:0] result,
    input  logic        carry_out,
    input  logic        nBo,
    input  logic        nGo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_nbo,
    output logic        rsp_ngo,
    output logic        busy
);

    localparam int              c_ptr_w       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int              c_cnt_w       = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(RSP_DEPTH);
    localparam logic [3:0]      c_settle_init = 4'(SETTLE_CYCLES - 1);

    localparam logic [0:0]      c_st_idle     = 1'b0;
    localparam logic [0:0]      c_st_wait     = 1'b1;

    logic [0:0]         r_state;
    logic [3:0]         r_settle_cnt;
    logic               r_carry_q;

    logic [18:0]        r_mem [RSP_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_accept;
    logic               w_capture;
    logic               w_pop;

    // Accept only with a free slot, so a later capture can never overflow.
    assign cmd_ready = !rst && (r_state == c_st_idle) && (r_count < c_depth);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_capture = (r_state == c_st_wait) && (r_settle_cnt == 4'd0);
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign busy      = (r_state == c_st_wait);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_settle_cnt <= 4'd0;
            r_carry_q    <= 1'b0;
            operand_a    <= 16'd0;
            operand_b    <= 16'd0;
            opcode       <= 4'd0;
            mode         <= 1'b0;
            carry_in     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        operand_a    <= cmd_a;
                        operand_b    <= cmd_b;
                        opcode       <= cmd_op;
                        mode         <= cmd_mode;
                        carry_in     <= cmd_chain ? r_carry_q : cmd_cin;
                        r_settle_cnt <= c_settle_init;
                        r_state      <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end else begin
                        r_carry_q <= carry_out;
                        r_state   <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (w_capture && !rst) begin
            r_mem[r_wr_ptr] <= {result, carry_out, nBo, nGo};
        end
    end

    assign {rsp_result, rsp_cout, rsp_nbo, rsp_ngo} = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_alu16_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu16_op_sequencer
// Brief    : Directed, table-driven bench for alu16_op_sequencer with a small
//            behavioural ALU model on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu16_op_sequencer;

    localparam int SETTLE = 4;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [3:0]  cmd_op;
    logic        cmd_mode, cmd_cin, cmd_chain;
    logic [15:0] operand_a, operand_b;
    logic [3:0]  opcode;
    logic        mode, carry_in;
    logic [15:0] result;
    logic        carry_out, nBo, nGo;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_cout, rsp_nbo, rsp_ngo, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu16_op_sequencer #(.SETTLE_CYCLES(SETTLE), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
        .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
        .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
        .mode(mode), .carry_in(carry_in),
        .result(result), .carry_out(carry_out), .nBo(nBo), .nGo(nGo),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .rsp_nbo(rsp_nbo), .rsp_ngo(rsp_ngo), .busy(busy)
    );

    // Reduced ALU: logic ops in mode 1, add with carry in mode 0.
    logic [16:0] w_sum;
    always_comb begin
        w_sum     = {1'b0, operand_a} + {1'b0, operand_b} + {16'd0, carry_in};
        result    = 16'd0;
        carry_out = 1'b0;
        if (mode) begin
            case (opcode)
                4'b0110: result = operand_a ^ operand_b;
                4'b1011: result = operand_a & operand_b;
                4'b1110: result = operand_a | operand_b;
                default: result = ~operand_a;
            endcase
        end else begin
            result    = w_sum[15:0];
            carry_out = w_sum[16];
        end
        nBo = result[15];
        nGo = (result == 16'd0);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        md;
        logic        cin;
        logic        chain;
        logic        exp_cin;
        logic [15:0] exp_res;
        logic        exp_cout;
        logic        exp_nbo;
        logic        exp_ngo;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic md, input logic cin, input logic chain);
        int n;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_mode = md; cmd_cin = cin; cmd_chain = chain;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int e;
        vecs[0] = '{16'h00FF, 16'h0F0F, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0000, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h00FF, 16'h1234, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_mode = 1'b0; cmd_cin = 1'b0; cmd_chain = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_operand_a", 32'(operand_a), 32'd0);
        check("rst_carry_in", 32'(carry_in), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single operations, one at a time
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].md, vecs[i].cin, vecs[i].chain);
            check($sformatf("v%0d_operand_a", i), 32'(operand_a), 32'(vecs[i].a));
            check($sformatf("v%0d_operand_b", i), 32'(operand_b), 32'(vecs[i].b));
            check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].op));
            check($sformatf("v%0d_carry_in", i), 32'(carry_in), 32'(vecs[i].exp_cin));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            check($sformatf("v%0d_cmd_ready_wait", i), 32'(cmd_ready), 32'd0);
            wait_rsp(e);
            check($sformatf("v%0d_latency", i), 32'(e), 32'(SETTLE));
            check($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].exp_res));
            check($sformatf("v%0d_cout", i), 32'(rsp_cout), 32'(vecs[i].exp_cout));
            check($sformatf("v%0d_nbo", i), 32'(rsp_nbo), 32'(vecs[i].exp_nbo));
            check($sformatf("v%0d_ngo", i), 32'(rsp_ngo), 32'(vecs[i].exp_ngo));
            check($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_operand_hold", i), 32'(operand_a), 32'(vecs[i].a));
            pop();
            check($sformatf("v%0d_empty", i), 32'(rsp_valid), 32'd0);
        end

        // Back-pressure: four buffered, fifth held until one pop
        for (int i = 1; i <= 4; i++) begin
            send(16'h0100 + 16'(i), 16'h0000, 4'b0110, 1'b1, 1'b0, 1'b0);
        end
        repeat (SETTLE + 2) @(negedge clk);
        check("bp_full_ready", 32'(cmd_ready), 32'd0);
        check("bp_full_valid", 32'(rsp_valid), 32'd1);
        check("bp_head", 32'(rsp_result), 32'h0101);
        cmd_a = 16'h0105; cmd_b = 16'h0000; cmd_op = 4'b0110; cmd_mode = 1'b1;
        cmd_cin = 1'b0; cmd_chain = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_held", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_fifth_accepted", 32'(operand_a), 32'h0105);
        for (int i = 2; i <= 5; i++) begin
            wait_rsp(e);
            check($sformatf("bp_order%0d", i), 32'(rsp_result), 32'h0100 + 32'(i));
            pop();
        end
        check("bp_drained", 32'(rsp_valid), 32'd0);

        // Simultaneous push and pop with one entry resident
        send(16'hAAAA, 16'h0000, 4'b0110, 1'b1, 1'b0, 1'b0);
        wait_rsp(e);
        send(16'h5555, 16'h0000, 4'b0110, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("pp_old_head", 32'(rsp_result), 32'hAAAA);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("pp_valid", 32'(rsp_valid), 32'd1);
        check("pp_new_head", 32'(rsp_result), 32'h5555);
        pop();
        check("pp_count_one", 32'(rsp_valid), 32'd0);

        // Reset in the middle of an operation, with a stored carry of 1
        send(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
        wait_rsp(e);
        check("mr_setup_cout", 32'(rsp_cout), 32'd1);
        pop();
        send(16'h1357, 16'h2468, 4'b0110, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mr_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check("mr_operand_a", 32'(operand_a), 32'd0);
        check("mr_operand_b", 32'(operand_b), 32'd0);
        check("mr_opcode_mode", 32'({opcode, mode, carry_in}), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_cmd_ready_after", 32'(cmd_ready), 32'd1);
        repeat (SETTLE + 4) @(posedge clk);
        #1;
        check("mr_no_response", 32'(rsp_valid), 32'd0);
        send(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b1);
        check("mr_chain_cin", 32'(carry_in), 32'd0);
        wait_rsp(e);
        check("mr_chain_result", 32'(rsp_result), 32'h0002);
        pop();

        // Pointer wrap with random response back-pressure
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(16'(i * 16'h0123), 16'h1000, 4'b1001, 1'b0, 1'b0, 1'b0);
                end
            end
            begin
                int got = 0;
                int cyc = 0;
                logic [15:0] exp_res;
                while (got < 10 && cyc < 800) begin
                    @(negedge clk);
                    rsp_ready = 1'($urandom_range(0, 1));
                    #1;
                    if (rsp_valid && rsp_ready) begin
                        exp_res = 16'(got * 16'h0123) + 16'h1000;
                        check($sformatf("wrap%0d", got), 32'(rsp_result), 32'(exp_res));
                        got++;
                    end
                    cyc++;
                end
                if (got < 10) check("wrap_timeout", 32'(got), 32'd10);
                @(negedge clk);
                rsp_ready = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("wrap_empty", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu16_op_sequencer.md
# alu16_op_sequencer

Command-driven master for the 16-bit ALU bus. It accepts operation commands over a valid/ready stream and drives `operand_a`, `operand_b`, `opcode`, `mode` and `carry_in` onto the ALU. After a programmable settle time it samples `result`, `carry_out`, `nBo` and `nGo`, and returns them through a first-word-fall-through response FIFO. It sits where the testbench driver sits today, which lets ALU operations be sequenced from RTL, including multi-word arithmetic via carry chaining.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles from the ALU inputs changing to the ALU outputs being sampled; legal range 1–15.
- `RSP_DEPTH`, default 4: response FIFO depth; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_a`  in  16  operand A.
- `cmd_b`  in  16  operand B.
- `cmd_op`  in  4  ALU opcode.
- `cmd_mode`  in  1  ALU mode.
- `cmd_cin`  in  1  explicit carry in.
- `cmd_chain`  in  1  when 1, use the stored carry instead of `cmd_cin`.
- `operand_a`  out  16  to the ALU.
- `operand_b`  out  16  to the ALU.
- `opcode`  out  4  to the ALU.
- `mode`  out  1  to the ALU.
- `carry_in`  out  1  to the ALU.
- `result`  in  16  from the ALU.
- `carry_out`  in  1  from the ALU.
- `nBo`  in  1  from the ALU.
- `nGo`  in  1  from the ALU.
- `rsp_valid`  out  1  FIFO head valid.
- `rsp_ready`  in  1  pop when `rsp_valid && rsp_ready`.
- `rsp_result`  out  16  FIFO head: captured result.
- `rsp_cout`  out  1  FIFO head: captured carry out.
- `rsp_nbo`  out  1  FIFO head: captured `nBo`.
- `rsp_ngo`  out  1  FIFO head: captured `nGo`.
- `busy`  out  1  an operation is in flight.

## Operation
- The FSM has two states, IDLE and WAIT.
- **IDLE:** `cmd_ready = (fifo_count < RSP_DEPTH)`.
  - On accept, register the command fields onto the ALU outputs.
  - `carry_in` takes `cmd_chain ? carry_q : cmd_cin`.
  - Load `settle_cnt = SETTLE_CYCLES-1` and go to WAIT.
- **WAIT:** `cmd_ready = 0` and `busy = 1`.
  - If `settle_cnt != 0`, decrement it.
  - If `settle_cnt == 0`, capture `{result, carry_out, nBo, nGo}`, push it into the FIFO, set `carry_q <= carry_out`, and go to IDLE.
- ALU outputs hold their values until the next accept; they do not return to 0 between operations.
- Only one operation is in flight at a time. Because accept requires a free slot and only this block pushes, a capture never finds the FIFO full.
- `carry_q` is updated only on capture, so chaining uses the most recent completed operation. After reset, a chained first command gets `carry_in = 0`.
- Carry and status bits are passed through unmodified; no polarity inversion is applied.
- **FIFO:** first-word-fall-through; the `rsp_*` fields are the head entry, valid when `rsp_valid = 1`.
  - When a push and a pop happen in the same cycle, the count is unchanged and order is preserved.
  - With an empty FIFO, a push makes `rsp_valid = 1` on the next cycle; there is no bypass in the same cycle.
  - Read and write pointers wrap modulo `RSP_DEPTH`.
- **Reset** (including mid-operation):
  - State goes to IDLE and the in-flight operation is discarded with no push.
  - The FIFO is flushed and `carry_q = 0`.
  - All ALU outputs are 0.
  - `rsp_valid = 0` and `busy = 0`.
  - `cmd_ready = 0` while `rst` is high and 1 in the first cycle after.

## Timing
- Accept at edge k: the ALU inputs are valid after edge k.
- Sample and push at edge k+`SETTLE_CYCLES`; `rsp_valid` rises after that edge if the FIFO was empty.
- Return to IDLE at the same edge k+`SETTLE_CYCLES`, so the next accept can occur at edge k+`SETTLE_CYCLES`+1.
- Throughput is one operation per `SETTLE_CYCLES`+1 cycles.
- `cmd_ready` is registered state plus FIFO count; it has no combinational path from `cmd_valid`.
- `rsp_valid` has no combinational path from `rsp_ready`.

## Test plan
- **Single XOR:** after reset, send A=0x00FF, B=0x0F0F, op=0110, mode=1. Required: `operand_a`=0x00FF after the accept edge; `rsp_valid` rises exactly `SETTLE_CYCLES` edges after accept; `rsp_result`=0x0FF0.
- **Carry chain:** the bench ALU model drives `carry_out`=1 for command 1 (`cmd_cin`=0). Send command 2 with `cmd_chain`=1. Required: `carry_in`=1 while command 2 is driven. With `cmd_chain`=0 and `cmd_cin`=0, `carry_in`=0.
- **Back-pressure:** hold `rsp_ready`=0 and stream 5 commands with `RSP_DEPTH`=4. Required: 4 responses are buffered, and `cmd_ready`=0 once `fifo_count`=4. After a single pop, the 5th command is accepted. Responses pop in command order.
- **Simultaneous push/pop:** keep 1 entry in the FIFO and `rsp_ready`=1 while a capture occurs. Required: the count stays 1 and the head is the newer result.
- **Reset mid-operation:** with `SETTLE_CYCLES`=4, assert `rst` 2 cycles after accept. Required: no response is produced; the ALU outputs, `busy` and `rsp_valid` are 0; a chained command after reset drives `carry_in`=0.
- **Pointer wrap:** send 10 commands with random `rsp_ready`. Required: all 10 results match the reference model, in order.
